// File: rtl/smc_apb_cfg_if27.sv
// APB3 configuration slave for the SMC: per-chip-select CFG bank, CTRL and STATUS,
// with programmable wait states, error responses and per-CS update strobes.
module smc_apb_cfg_if27 #(
   parameter int                NUM_CS   = 4,
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 5,
   parameter int                WAIT_CYC = 0,
   parameter logic [DATA_W-1:0] CFG_RST  = '0
) (
   input  logic                     pclk27,
   input  logic                     preset27,
   input  logic                     psel27,
   input  logic                     penable27,
   input  logic                     pwrite27,
   input  logic [ADDR_W-1:0]        paddr27,
   input  logic [DATA_W-1:0]        pwdata27,
   output logic [DATA_W-1:0]        prdata27,
   output logic                     pready27,
   output logic                     pslverr27,
   output logic [NUM_CS*DATA_W-1:0] cfg_bus27,
   output logic                     cfg_en27,
   output logic [NUM_CS-1:0]        cfg_upd27
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [1:0] WAIT_LD = 2'(WAIT_CYC);

   state_t            state, state_nxt;
   logic [1:0]        wcnt, wcnt_nxt;
   logic [DATA_W-1:0] cfg_q [NUM_CS];
   logic [7:0]        err_cnt;
   logic [DATA_W-1:0] rdata;
   logic [2:0]        idx;
   logic              setup, access, start, commit;
   logic              is_cfg, is_ctrl, is_stat, bad, wr_ok;

   assign idx    = paddr27[4:2];
   assign setup  = psel27 & ~penable27;
   assign access = psel27 & penable27;
   assign start  = setup & (state != S_WAIT);
   assign commit = (state == S_RESP) & access;

   assign is_cfg  = (idx < 3'(NUM_CS));
   assign is_ctrl = (idx == 3'd6);
   assign is_stat = (idx == 3'd7);
   assign bad     = (paddr27[1:0] != 2'b00) | ~(is_cfg | is_ctrl | is_stat) | (pwrite27 & is_stat);
   assign wr_ok   = commit & pwrite27 & ~bad;

   always_ff @(posedge pclk27 or posedge preset27) begin
      if (preset27) begin
         state <= S_IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   // wcnt holds the access cycles still to be spent in WAIT, counting the current one;
   // with no wait states the setup phase leads straight into the response cycle.
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      case (state)
         S_IDLE: state_nxt = S_IDLE;
         S_WAIT: begin
            if (!psel27) begin
               state_nxt = S_IDLE;
            end else if (penable27) begin
               if (wcnt <= 2'd1) begin
                  state_nxt = S_RESP;
                  wcnt_nxt  = '0;
               end else begin
                  wcnt_nxt = wcnt - 2'd1;
               end
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (start) begin
         if (WAIT_CYC == 0) begin
            state_nxt = S_RESP;
         end else begin
            state_nxt = S_WAIT;
            wcnt_nxt  = WAIT_LD;
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int k = 0; k < NUM_CS; k++) begin
         if (idx == 3'(k)) rdata = cfg_q[k];
      end
      if (is_ctrl) rdata[0] = cfg_en27;
      if (is_stat) begin
         rdata[7:0]  = err_cnt;
         rdata[15:8] = 8'(NUM_CS);
         rdata[16]   = cfg_en27;
      end
   end

   assign pready27  = (state == S_RESP);
   assign pslverr27 = commit & bad;
   assign prdata27  = (commit & ~pwrite27 & ~bad) ? rdata : '0;

   // Register writes and the error counter only move on the response edge.
   always_ff @(posedge pclk27 or posedge preset27) begin
      if (preset27) begin
         for (int k = 0; k < NUM_CS; k++) cfg_q[k] <= CFG_RST;
         cfg_upd27 <= '0;
         cfg_en27  <= 1'b0;
         err_cnt   <= '0;
      end else begin
         cfg_upd27 <= '0;
         for (int k = 0; k < NUM_CS; k++) begin
            if (wr_ok && is_cfg && (idx == 3'(k))) begin
               cfg_q[k]     <= pwdata27;
               cfg_upd27[k] <= 1'b1;
            end
         end
         if (wr_ok && is_ctrl) cfg_en27 <= pwdata27[0];
         if (commit && bad) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end else if (wr_ok && is_ctrl && pwdata27[1]) begin
            err_cnt <= '0;
         end
      end
   end

   for (genvar g = 0; g < NUM_CS; g++) begin : g_bus
      assign cfg_bus27[g*DATA_W +: DATA_W] = cfg_q[g];
   end

endmodule

// File: tb/tb_smc_apb_cfg_if27.sv
// Directed bench for smc_apb_cfg_if27: a zero-wait and a three-wait instance share the
// APB inputs; each step drives one transfer and checks the addressed instance.
module tb_smc_apb_cfg_if27;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [4:0]   paddr = '0;
   logic [31:0]  pwdata = '0;

   logic [31:0]  prdata0, prdata3;
   logic         pready0, pready3, pslverr0, pslverr3, cfg_en0, cfg_en3;
   logic [127:0] cfg_bus0, cfg_bus3;
   logic [3:0]   cfg_upd0, cfg_upd3;

   int           checks = 0;
   int           failures = 0;
   logic [31:0]  rd;
   logic         er;
   int           cyc;

   always #5 clk = ~clk;

   smc_apb_cfg_if27 #(.WAIT_CYC(0)) dut0 (
      .pclk27(clk), .preset27(rst), .psel27(psel), .penable27(penable), .pwrite27(pwrite),
      .paddr27(paddr), .pwdata27(pwdata), .prdata27(prdata0), .pready27(pready0),
      .pslverr27(pslverr0), .cfg_bus27(cfg_bus0), .cfg_en27(cfg_en0), .cfg_upd27(cfg_upd0)
   );

   smc_apb_cfg_if27 #(.WAIT_CYC(3)) dut3 (
      .pclk27(clk), .preset27(rst), .psel27(psel), .penable27(penable), .pwrite27(pwrite),
      .paddr27(paddr), .pwdata27(pwdata), .prdata27(prdata3), .pready27(pready3),
      .pslverr27(pslverr3), .cfg_bus27(cfg_bus3), .cfg_en27(cfg_en3), .cfg_upd27(cfg_upd3)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One APB transfer; returns sampled prdata/pslverr of the chosen instance and the
   // number of access cycles up to and including the one with pready high.
   task automatic applyStimulus(input bit use3, input bit wr, input logic [4:0] addr,
                                input logic [31:0] wd, output logic [31:0] rdat,
                                output logic serr, output int ncyc);
      bit got;
      got  = 1'b0;
      rdat = 'x;
      serr = 1'bx;
      ncyc = 0;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      while (!got && ncyc < 10) begin
         ncyc++;
         @(negedge clk);
         if ((use3 ? pready3 : pready0) === 1'b1) begin
            got  = 1'b1;
            rdat = use3 ? prdata3 : prdata0;
            serr = use3 ? pslverr3 : pslverr0;
         end
         @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      checkOutput("ready_seen", 32'(got), 32'd1);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      checkOutput("rst_pready", 32'(pready0), 32'd0);
      checkOutput("rst_pslverr", 32'(pslverr0), 32'd0);
      checkOutput("rst_prdata", prdata0, 32'h0);
      checkOutput("rst_upd", 32'(cfg_upd0), 32'h0);
      checkOutput("rst_en", 32'(cfg_en0), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Read every mapped register after reset, zero wait states
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b0, 5'(k * 4), 32'h0, rd, er, cyc);
         checkOutput("rd_cfg_rst", rd, 32'h0);
         checkOutput("rd_cfg_err", 32'(er), 32'd0);
         checkOutput("rd_cfg_lat", 32'(cyc), 32'd1);
      end
      applyStimulus(1'b0, 1'b0, 5'h1C, 32'h0, rd, er, cyc);
      checkOutput("rd_status_rst", rd, 32'h0000_0400);
      checkOutput("rd_status_err", 32'(er), 32'd0);
      applyStimulus(1'b0, 1'b0, 5'h18, 32'h0, rd, er, cyc);
      checkOutput("rd_ctrl_rst", rd, 32'h0);

      // CFG writes, update strobes and read-back
      applyStimulus(1'b0, 1'b1, 5'h08, 32'hDEAD_BEEF, rd, er, cyc);
      checkOutput("wr_cfg2_err", 32'(er), 32'd0);
      checkOutput("wr_cfg2_upd", 32'(cfg_upd0), 32'h4);
      checkOutput("wr_cfg2_bus", cfg_bus0[95:64], 32'hDEAD_BEEF);
      @(posedge clk); #1;
      checkOutput("wr_cfg2_upd_off", 32'(cfg_upd0), 32'h0);
      applyStimulus(1'b0, 1'b0, 5'h08, 32'h0, rd, er, cyc);
      checkOutput("rd_cfg2", rd, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b1, 5'h0C, 32'hA5A5_5A5A, rd, er, cyc);
      checkOutput("wr_cfg3_upd", 32'(cfg_upd0), 32'h8);
      checkOutput("wr_cfg3_bus", cfg_bus0[127:96], 32'hA5A5_5A5A);
      checkOutput("cfg0_untouched", cfg_bus0[31:0], 32'h0);

      // Error responses and the error counter
      applyStimulus(1'b0, 1'b1, 5'h14, 32'h1234_5678, rd, er, cyc);
      checkOutput("err_idx5", 32'(er), 32'd1);
      checkOutput("err_idx5_rd", rd, 32'h0);
      checkOutput("err_idx5_upd", 32'(cfg_upd0), 32'h0);
      applyStimulus(1'b0, 1'b1, 5'h1C, 32'hFFFF_FFFF, rd, er, cyc);
      checkOutput("err_wr_status", 32'(er), 32'd1);
      applyStimulus(1'b0, 1'b0, 5'h01, 32'h0, rd, er, cyc);
      checkOutput("err_misalign", 32'(er), 32'd1);
      checkOutput("err_misalign_rd", rd, 32'h0);
      applyStimulus(1'b0, 1'b0, 5'h1C, 32'h0, rd, er, cyc);
      checkOutput("status_err3", rd, 32'h0000_0403);
      applyStimulus(1'b0, 1'b0, 5'h0A, 32'h0, rd, er, cyc);
      checkOutput("err_misalign_cfg2_rd", rd, 32'h0);
      applyStimulus(1'b0, 1'b1, 5'h10, 32'h5555_AAAA, rd, er, cyc);
      checkOutput("err_idx4", 32'(er), 32'd1);
      checkOutput("err_cfg_bus_keep", cfg_bus0[95:64], 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b0, 5'h1C, 32'h0, rd, er, cyc);
      checkOutput("status_err5", rd, 32'h0000_0405);
      for (int i = 0; i < 255; i++) applyStimulus(1'b0, 1'b0, 5'h14, 32'h0, rd, er, cyc);
      applyStimulus(1'b0, 1'b0, 5'h1C, 32'h0, rd, er, cyc);
      checkOutput("status_sat", rd, 32'h0000_04FF);

      // CTRL: enable plus clear-error
      applyStimulus(1'b0, 1'b1, 5'h18, 32'h0000_0003, rd, er, cyc);
      checkOutput("ctrl_wr_err", 32'(er), 32'd0);
      checkOutput("ctrl_en", 32'(cfg_en0), 32'd1);
      applyStimulus(1'b0, 1'b0, 5'h1C, 32'h0, rd, er, cyc);
      checkOutput("status_cleared", rd, 32'h0001_0400);
      applyStimulus(1'b0, 1'b0, 5'h18, 32'h0, rd, er, cyc);
      checkOutput("ctrl_rd", rd, 32'h0000_0001);

      // Reset while the three-wait instance waits on a CFG[0] write
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      checkOutput("mid_wait_pready3", 32'(pready3), 32'd0);
      checkOutput("mid_resp_pready0", 32'(pready0), 32'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("async_rst_pready0", 32'(pready0), 32'd0);
      checkOutput("async_rst_en0", 32'(cfg_en0), 32'd0);
      checkOutput("async_rst_pready3", 32'(pready3), 32'd0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst_cfg0_dut3", cfg_bus3[31:0], 32'h0);
      checkOutput("rst_cfg0_dut0", cfg_bus0[31:0], 32'h0);
      checkOutput("rst_cfg2_dut0", cfg_bus0[95:64], 32'h0);

      // Three wait states: latency, write, error, abort
      applyStimulus(1'b1, 1'b0, 5'h18, 32'h0, rd, er, cyc);
      checkOutput("w3_ctrl_lat", 32'(cyc), 32'd4);
      checkOutput("w3_ctrl_rd", rd, 32'h0);
      applyStimulus(1'b1, 1'b1, 5'h04, 32'h1111_2222, rd, er, cyc);
      checkOutput("w3_wr_lat", 32'(cyc), 32'd4);
      checkOutput("w3_wr_upd", 32'(cfg_upd3), 32'h2);
      applyStimulus(1'b1, 1'b0, 5'h04, 32'h0, rd, er, cyc);
      checkOutput("w3_rd_cfg1", rd, 32'h1111_2222);
      applyStimulus(1'b1, 1'b1, 5'h1C, 32'h0, rd, er, cyc);
      checkOutput("w3_err_status", 32'(er), 32'd1);

      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      checkOutput("abort_pready_a", 32'(pready3), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("abort_pready_b", 32'(pready3), 32'd0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("abort_no_ready", 32'(pready3), 32'd0);
      end
      checkOutput("abort_cfg1_keep", cfg_bus3[63:32], 32'h1111_2222);
      checkOutput("abort_no_upd", 32'(cfg_upd3), 32'h0);
      applyStimulus(1'b1, 1'b0, 5'h1C, 32'h0, rd, er, cyc);
      checkOutput("abort_status", rd, 32'h0000_0401);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
